// File: rtl/display_scan_controller.sv
// display_scan_controller
//   Captures an unsigned binary value on a load handshake and converts it to
//   four BCD digits with a sequential shift-add-3 engine (one bit per clock).
//   The stored digits are time-multiplexed onto one active-low 7-segment bus
//   with a rotating one-hot active-low digit enable. Values of 10000 and up
//   display four dashes and raise overflow.
//
// Ports
//   clock    : system clock, rising edge
//   reset    : synchronous, active-low reset
//   binary   : [WIDTH-1:0] value to display
//   load     : capture request, taken only while the controller is idle
//   busy     : high while a conversion is in progress
//   overflow : last accepted value was >= 10000
//   seg      : [6:0] segments a..g on bits 0..6, active-low
//   an       : [3:0] digit enables, active-low one-hot, bit0 = ones
//
// Build option
//   LEADING_ZERO_BLANK_EN : when defined, leading zero digits above the ones
//   digit are blanked at commit time. Dashes are never blanked.

module display_scan_controller #(
  parameter int SCAN_DIV = 50000,
  parameter int WIDTH    = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] binary,
  input  logic             load,
  output logic             busy,
  output logic             overflow,
  output logic [6:0]       seg,
  output logic [3:0]       an
);

  localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [6:0]       SEG_DASH  = 7'b0111111;
  localparam logic [6:0]       SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  state_t           r_state;
  logic [13:0]      r_shift;
  logic [15:0]      r_bcd;
  logic [3:0]       r_iter;
  logic             r_ovf_cap;
  logic [15:0]      r_digits;
  logic             r_dash;
  logic [3:0]       r_blank;
  logic             r_ovf_disp;
  logic [CNT_W-1:0] r_scan_cnt;

  logic             w_wrap;
  logic [3:0]       w_an_next;
  logic [3:0]       w_nib;
  logic             w_blk;
  logic [6:0]       w_seg_next;
  logic [15:0]      w_bcd_adj;

  function automatic logic [15:0] bcd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] >= 4'd5) r[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blanked only if it and every digit above it are zero.
  function automatic logic [3:0] blank_mask(input logic [15:0] b);
    logic [3:0] m;
    m[3] = (b[15:12] == 4'd0);
    m[2] = m[3] && (b[11:8] == 4'd0);
    m[1] = m[2] && (b[7:4] == 4'd0);
    m[0] = 1'b0;
    return m;
  endfunction
`endif

  assign w_bcd_adj = bcd_adjust(r_bcd);

  // Conversion FSM; busy/overflow are registered one edge behind the state
  // so that they line up with the registered segment output.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_iter     <= 4'd0;
      r_ovf_cap  <= 1'b0;
      r_digits   <= 16'd0;
      r_dash     <= 1'b0;
      r_blank    <= 4'b0000;
      r_ovf_disp <= 1'b0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      busy     <= (r_state != IDLE);
      overflow <= r_ovf_disp;
      case (r_state)
        IDLE: begin
          if (load) begin
            if (binary >= WIDTH'(10000)) begin
              r_ovf_cap <= 1'b1;
              r_state   <= COMMIT;
            end else begin
              r_ovf_cap <= 1'b0;
              r_shift   <= binary[13:0];
              r_bcd     <= 16'd0;
              r_iter    <= 4'd14;
              r_state   <= CONVERT;
            end
          end
        end
        CONVERT: begin
          {r_bcd, r_shift} <= {w_bcd_adj[14:0], r_shift, 1'b0};
          r_iter           <= r_iter - 4'd1;
          if (r_iter == 4'd1) r_state <= COMMIT;
        end
        COMMIT: begin
          r_dash     <= r_ovf_cap;
          r_ovf_disp <= r_ovf_cap;
          if (!r_ovf_cap) r_digits <= r_bcd;
`ifdef LEADING_ZERO_BLANK_EN
          r_blank    <= r_ovf_cap ? 4'b0000 : blank_mask(r_bcd);
`else
          r_blank    <= 4'b0000;
`endif
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Scan: seg is decoded from the digit the next enable points at, so an and
  // seg change on the same edge.
  assign w_wrap    = (r_scan_cnt == SCAN_LAST);
  assign w_an_next = w_wrap ? {an[2:0], an[3]} : an;

  always_comb begin
    w_nib = r_digits[3:0];
    w_blk = r_blank[0];
    case (w_an_next)
      4'b1101: begin w_nib = r_digits[7:4];   w_blk = r_blank[1]; end
      4'b1011: begin w_nib = r_digits[11:8];  w_blk = r_blank[2]; end
      4'b0111: begin w_nib = r_digits[15:12]; w_blk = r_blank[3]; end
      default: begin w_nib = r_digits[3:0];   w_blk = r_blank[0]; end
    endcase
  end

  assign w_seg_next = r_dash ? SEG_DASH : (w_blk ? SEG_BLANK : seg_decode(w_nib));

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_scan_cnt <= '0;
      an         <= 4'b1110;
      seg        <= 7'b1000000;
    end else begin
      r_scan_cnt <= w_wrap ? '0 : r_scan_cnt + 1'b1;
      an         <= w_an_next;
      seg        <= w_seg_next;
    end
  end

endmodule
